seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
//   Sequential unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
//   Shift-and-subtract, one trial subtraction per clock, same borrow/complement arithmetic as the add/sub datapath.
//   Inverse-operation companion to the parallel adder/subtractor.
//   Sits behind a valid/ready request port and returns results on a valid/ready response port.
// PARAMETERS
//   WIDTH   4   operand, quotient and remainder width in bits (>=2)
// PORTS
//   clk        in   1      rising-edge clock, single clock domain
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request valid; dividend/divisor sampled when in_valid & in_ready
//   in_ready   out  1      block idle, request can be accepted
//   dividend   in   WIDTH  unsigned dividend
//   divisor    in   WIDTH  unsigned divisor
//   out_valid  out  1      quotient/remainder/div_err valid
//   out_ready  in   1      consumer accepts result when out_valid & out_ready
//   quotient   out  WIDTH  unsigned quotient
//   remainder  out  WIDTH  unsigned remainder
//   div_err    out  1      divide-by-zero flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; in_ready=1 once released; out_valid=0; quotient=0; remainder=0; div_err=0; counter=0.
//   FSM states: IDLE, RUN, DONE. All outputs are registered.
//   IDLE: in_ready=1. On in_valid:
//     - Load Q<=dividend, R<=0, D<=divisor, cnt<=WIDTH-1.
//     - Go to RUN.
//   RUN: in_ready=0. Each cycle:
//     - {R,Q} <= {R,Q}<<1.
//     - trial = {1'b0,R_shifted} - {1'b0,D}, computed in WIDTH+1 bits.
//     - If trial[WIDTH]==0 (no borrow): R<=trial[WIDTH-1:0], Q[0]<=1.
//     - Else: R kept (restored), Q[0]<=0.
//     - cnt decrements; after the cnt==0 iteration go to DONE.
//   Latency: out_valid rises exactly WIDTH clocks after the accepting edge (4 for default).
//   DONE: out_valid=1. quotient/remainder/div_err held stable while out_ready=0 (unbounded backpressure).
//     - On out_ready: out_valid<=0, go to IDLE.
//     - A new request is accepted no earlier than the cycle after the result handshake; no overlap.
//   in_valid is ignored outside IDLE; dividend/divisor changes after acceptance have no effect.
//   Boundaries:
//     - dividend < divisor: q=0, r=dividend.
//     - divisor=1: q=dividend, r=0.
//     - dividend=0: q=0, r=0.
//     - All-ones operands: q=1, r=0.
//   Reset mid-RUN or mid-DONE: immediate abort to reset values; the in-flight result is discarded.
// CONFIGURATION
//   Macro DIVIDER_DIV_ZERO_ERR_EN:
//     defined:
//       - divisor==0 at accept skips RUN and goes directly to DONE.
//       - out_valid rises 1 clock after the accepting edge with quotient=0, remainder=0, div_err=1.
//       - div_err=0 for every nonzero divisor.
//     undefined:
//       - divisor==0 runs the normal WIDTH-cycle iteration.
//       - Result: quotient=all ones, remainder=dividend.
//       - div_err is tied to 0.
// TESTING
//   T1: 13/4 -> q=3, r=1, out_valid exactly 4 clocks after accept, in_ready=0 meanwhile.
//   T2: 15/1 -> q=15, r=0; 0/7 -> q=0, r=0; 5/9 -> q=0, r=5; 15/15 -> q=1, r=0.
//   T3: 9/0 -> macro off: q=15, r=9, div_err=0 after 4 clocks; macro on: q=0, r=0, div_err=1 after 1 clock.
//   T4: out_ready held 0 for 6 cycles after 11/3 -> q=3, r=2 held stable; in_valid pulses ignored; next accept only after handshake.
//   T5: rst_n pulsed low during RUN of 14/3 -> outputs zero asynchronously; after release, 7/2 -> q=3, r=1 correct.
//   T6: WIDTH=8, back-to-back 200/7 then 255/16 -> q=28 r=4, then q=15 r=15, each 8 clocks after accept.

Source files
------------

// File: rtl/seq_restoring_divider_if.sv
// Request/response bundle for the sequential restoring divider.
//   in_valid/in_ready   : request handshake carrying dividend/divisor
//   out_valid/out_ready : response handshake carrying quotient/remainder/div_err
// slave  : divider side
// master : requester/consumer side
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_err;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_err
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_err
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one trial subtraction per clock.
//   quotient = dividend / divisor, remainder = dividend % divisor.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   io     : seq_restoring_divider_if.slave
//            request  in_valid/in_ready, dividend, divisor
//            response out_valid/out_ready, quotient, remainder, div_err
// Timing: result valid WIDTH clocks after the accepting edge; held under
// backpressure until out_ready. One operation in flight at a time.
// Optional build macro DIVIDER_DIV_ZERO_ERR_EN:
//   defined   - divisor==0 returns q=0, r=0, div_err=1 one clock after accept.
//   undefined - divisor==0 iterates normally (q=all ones, r=dividend), div_err=0.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_restoring_divider_if.slave io
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r, r_r, d_r;   // working quotient/remainder/divisor
  logic [WIDTH-1:0] q_o, r_o;        // registered results
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_sh, trial;
  logic [WIDTH-1:0] q_nxt, r_nxt;
  logic             zdiv_r;          // divisor was zero at accept
  logic             last;

  // Partial remainder never exceeds the dividend prefix shifted in so far,
  // so bit WIDTH of the shifted remainder is always zero and the trial
  // subtraction fits in WIDTH+1 bits with trial[WIDTH] as the borrow.
  assign r_sh  = {r_r, q_r[WIDTH-1]};
  assign trial = r_sh - {1'b0, d_r};
  assign q_nxt = {q_r[WIDTH-2:0], ~trial[WIDTH]};
  assign r_nxt = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign last  = (cnt == '0) || zdiv_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.in_valid) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
      r_r <= '0;
      d_r <= '0;
      cnt <= '0;
      q_o <= '0;
      r_o <= '0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          q_r <= io.dividend;
          r_r <= '0;
          d_r <= io.divisor;
          cnt <= CW'(WIDTH - 1);
        end
        RUN: begin
          q_r <= q_nxt;
          r_r <= r_nxt;
          cnt <= cnt - 1'b1;
          if (last) begin
            q_o <= zdiv_r ? '0 : q_nxt;
            r_o <= zdiv_r ? '0 : r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIVIDER_DIV_ZERO_ERR_EN
  logic err_o;

  // Divide-by-zero takes a single pass through RUN without iterating,
  // which lands the flagged result one clock after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zdiv_r <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (state == IDLE && io.in_valid) zdiv_r <= (io.divisor == '0);
      if (state == RUN && last)         err_o  <= zdiv_r;
    end
  end

  assign io.div_err = err_o;
`else
  assign zdiv_r     = 1'b0;
  assign io.div_err = 1'b0;
`endif

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.quotient  = q_o;
  assign io.remainder = r_o;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: WIDTH=4 and WIDTH=8 instances.
// Driver pushes hand-computed expectations at accept; monitor pops on the
// result handshake and checks data, latency, hold stability and in_ready.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(4)) if4 ();
  seq_restoring_divider_if #(.WIDTH(8)) if8 ();

  seq_restoring_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(if4.slave));
  seq_restoring_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(if8.slave));

  logic [1:0]      iv, ordy, ov, ir, er;
  logic [1:0][7:0] dvd, dvs, qo, ro;

  assign if4.in_valid  = iv[0];
  assign if4.dividend  = dvd[0][3:0];
  assign if4.divisor   = dvs[0][3:0];
  assign if4.out_ready = ordy[0];
  assign if8.in_valid  = iv[1];
  assign if8.dividend  = dvd[1];
  assign if8.divisor   = dvs[1];
  assign if8.out_ready = ordy[1];

  assign ov = {if8.out_valid, if4.out_valid};
  assign ir = {if8.in_ready, if4.in_ready};
  assign er = {if8.div_err, if4.div_err};
  assign qo = {if8.quotient, 4'h0, if4.quotient};
  assign ro = {if8.remainder, 4'h0, if4.remainder};

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise [2];
  logic [1:0] pov = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for one DUT: in_ready must be low while a result is pending,
  // result fields checked every cycle out_valid is high (hold stability).
  task automatic mon(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? sb0.size() : sb1.size();
    chk($sformatf("in_ready_w%0d", d), {31'd0, ir[d]}, {31'd0, n == 0});
    if (ov[d] && !pov[d]) rise[d] = cyc;
    if (ov[d]) begin
      if (n == 0) begin
        chk($sformatf("spurious_out_valid_w%0d", d), {31'd0, ov[d]}, 32'd0);
      end else begin
        e = (d == 0) ? sb0[0] : sb1[0];
        chk($sformatf("quotient_w%0d", d),  {24'd0, qo[d]}, {24'd0, e.q});
        chk($sformatf("remainder_w%0d", d), {24'd0, ro[d]}, {24'd0, e.r});
        chk($sformatf("div_err_w%0d", d),   {31'd0, er[d]}, {31'd0, e.e});
        chk($sformatf("latency_w%0d", d),   rise[d] - e.acc, e.lat);
        if (ordy[d]) begin
          if (d == 0) void'(sb0.pop_front());
          else        void'(sb1.pop_front());
        end
      end
    end
    pov[d] = ov[d];
  endtask

  always @(negedge clk) begin
    if (!rst_n) pov = 2'b00;
    else for (int d = 0; d < 2; d++) mon(d);
  end

  // Issue one request from posedge+1; waits (bounded) for in_ready.
  task automatic send(input int d, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] q, input logic [7:0] r, input logic e, input int lat);
    exp_t x;
    int   t = 0;
    iv[d] = 1'b1; dvd[d] = a; dvs[d] = b;
    while (!ir[d] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      chk($sformatf("accept_timeout_w%0d", d), 32'd0, 32'd1);
      iv[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    x.q = q; x.r = r; x.e = e; x.lat = lat; x.acc = cyc;
    if (d == 0) sb0.push_back(x);
    else        sb1.push_back(x);
    // operands change after acceptance must not matter
    iv[d] = 1'b0; dvd[d] = ~a; dvs[d] = b ^ 8'h5a;
  endtask

  task automatic wait_done(input int d);
    int t = 0;
    while (((d == 0) ? sb0.size() : sb1.size()) > 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      chk($sformatf("result_timeout_w%0d", d), 32'd0, 32'd1);
      sb0.delete(); sb1.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    iv = '0; ordy = 2'b11; dvd = '0; dvs = '0;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_out_valid", {30'd0, ov}, 32'd0);
    chk("rst_div_err",   {30'd0, er}, 32'd0);
    chk("rst_quotient",  {16'd0, qo}, 32'd0);
    chk("rst_remainder", {16'd0, ro}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {30'd0, ir}, 32'd3);

    // T1 / T2: basic and boundary vectors
    send(0, 8'd13, 8'd4, 8'd3, 8'd1, 1'b0, 4);
    send(0, 8'd15, 8'd1, 8'd15, 8'd0, 1'b0, 4);
    send(0, 8'd0, 8'd7, 8'd0, 8'd0, 1'b0, 4);
    send(0, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 4);
    send(0, 8'd15, 8'd15, 8'd1, 8'd0, 1'b0, 4);

    // T3: divide by zero
`ifdef DIVIDER_DIV_ZERO_ERR_EN
    send(0, 8'd9, 8'd0, 8'd0, 8'd0, 1'b1, 1);
`else
    send(0, 8'd9, 8'd0, 8'd15, 8'd9, 1'b0, 4);
`endif
    send(0, 8'd6, 8'd2, 8'd3, 8'd0, 1'b0, 4);
    wait_done(0);

    // T4: backpressure, in_valid pulses while result pending are ignored
    ordy[0] = 1'b0;
    send(0, 8'd11, 8'd3, 8'd3, 8'd2, 1'b0, 4);
    repeat (5) @(posedge clk);
    #1;
    iv[0] = 1'b1; dvd[0] = 8'd2; dvs[0] = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    wait_done(0);

    // T5: reset mid-RUN discards the in-flight result
    send(0, 8'd14, 8'd3, 8'd4, 8'd2, 1'b0, 4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    sb0.delete(); sb1.delete();
    chk("midrun_rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("midrun_rst_quotient",  {24'd0, qo[0]}, 32'd0);
    chk("midrun_rst_remainder", {24'd0, ro[0]}, 32'd0);
    chk("midrun_rst_in_ready",  {31'd0, ir[0]}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 8'd7, 8'd2, 8'd3, 8'd1, 1'b0, 4);
    wait_done(0);

    // T6: WIDTH=8 back-to-back
    send(1, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8);
    send(1, 8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 8);
    send(1, 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8);
    send(1, 8'd100, 8'd201, 8'd0, 8'd100, 1'b0, 8);
    wait_done(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
